// File: rtl/fanin_merge_rr_if.sv
// Stream bundle for the round-robin fan-in merge: per-input config and
// producer handshakes on one side, the merged consumer stream on the other.
interface fanin_merge_rr_if #(
  parameter int unsigned NUM_IN = 9,
  parameter int unsigned DW     = 17
);
  logic [NUM_IN-1:0]    en;
  logic [NUM_IN-1:0]    sel;
  logic [NUM_IN-1:0]    in_valid;
  logic [NUM_IN*DW-1:0] in_data;
  logic [NUM_IN-1:0]    in_ready;
  logic                 out_valid;
  logic [DW-1:0]        out_data;
  logic                 out_ready;

  // Merge block side
  modport slave (
    input  en, sel, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  // Producer/consumer/config side
  modport master (
    output en, sel, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/fanin_merge_rr.sv
// Round-robin merge of NUM_IN ready/valid producers into one consumer stream
// through a 2-entry buffer, so in_ready never depends on out_ready.
module fanin_merge_rr #(
  parameter int unsigned NUM_IN = 9,
  parameter int unsigned DW     = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  fanin_merge_rr_if.slave  bus
);
  localparam int unsigned PW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              head_q, head_d;
  logic [DW-1:0]     mem_q [2];
  logic [DW-1:0]     mem_d [2];
  logic              out_valid_q, out_valid_d;
  logic [DW-1:0]     out_data_q, out_data_d;

  logic [NUM_IN-1:0] eligible;
  logic [NUM_IN-1:0] grant;
  logic              grant_any;
  logic [PW-1:0]     grant_idx;
  logic [PW:0]       sum;
  logic              push, pop, tail;

  // Round-robin grant: first eligible input at or after rr_ptr, only when a slot is free
  always_comb begin
    eligible  = bus.en & bus.sel & bus.in_valid;
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    sum       = '0;
    if (rst_n && (count_q != 2'd2)) begin
      for (int unsigned k = 0; k < NUM_IN; k++) begin
        sum = {1'b0, rr_ptr_q} + (PW+1)'(k);
        if (sum >= (PW+1)'(NUM_IN)) sum = sum - (PW+1)'(NUM_IN);
        if (!grant_any && eligible[sum[PW-1:0]]) begin
          grant_any = 1'b1;
          grant_idx = sum[PW-1:0];
        end
      end
      if (grant_any) grant[grant_idx] = 1'b1;
    end
    bus.in_ready = grant;
  end

  // Buffer bookkeeping; the head register is loaded from the post-update buffer
  // so out_valid/out_data come straight from flops
  always_comb begin
    push     = grant_any;
    pop      = out_valid_q & bus.out_ready;
    mem_d    = mem_q;
    head_d   = head_q;
    count_d  = count_q;
    rr_ptr_d = rr_ptr_q;
    tail     = head_q ^ count_q[0];
    if (push) begin
      mem_d[tail] = bus.in_data[grant_idx*DW +: DW];
      rr_ptr_d    = (grant_idx == PW'(NUM_IN - 1)) ? '0 : grant_idx + 1'b1;
    end
    if (pop) head_d = ~head_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    out_valid_d = (count_d != 2'd0);
    out_data_d  = mem_d[head_d];
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      count_q     <= '0;
      head_q      <= 1'b0;
      mem_q[0]    <= '0;
      mem_q[1]    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      count_q     <= count_d;
      head_q      <= head_d;
      mem_q       <= mem_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_fanin_merge_rr.sv
// Bench for fanin_merge_rr: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fanin_merge_rr;
  localparam int unsigned N = 9;
  localparam int unsigned W = 17;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fanin_merge_rr_if #(.NUM_IN(N), .DW(W)) bus ();
  fanin_merge_rr #(.NUM_IN(N), .DW(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int          tests = 0;
  int          fails = 0;
  int unsigned seq   = 0;
  int unsigned rr    = 0;
  logic [W-1:0] mq[$];
  logic [N-1:0] hs = '0;
  bit           rand_mode = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference grant: buffer holds fewer than two tokens, first eligible from rr
  function automatic logic [N-1:0] model_grant();
    logic [N-1:0] g;
    int unsigned  i;
    g = '0;
    if (rst_n && mq.size() < 2) begin
      for (int unsigned k = 0; k < N; k++) begin
        i = (rr + k) % N;
        if (bus.en[i] && bus.sel[i] && bus.in_valid[i]) begin
          g[i] = 1'b1;
          break;
        end
      end
    end
    return g;
  endfunction

  // Model update on each clock edge
  always @(posedge clk) begin : model
    logic [N-1:0] g;
    if (!rst_n) begin
      mq.delete();
      rr = 0;
    end else begin
      g = model_grant();
      if (mq.size() != 0 && bus.out_ready) void'(mq.pop_front());
      for (int unsigned i = 0; i < N; i++)
        if (g[i]) begin
          mq.push_back(bus.in_data[i*W +: W]);
          rr = (i + 1) % N;
        end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    #1;
    check("in_ready", 32'(bus.in_ready), 32'(model_grant()));
    check("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) check("out_data", 32'(bus.out_data), 32'(mq[0]));
  end

  task automatic new_tok(input int unsigned i);
    bus.in_data[i*W +: W] = {4'(i), 13'(seq)};
    seq++;
  endtask

  task automatic mid();
    @(negedge clk);
    #2;
    hs = bus.in_valid & bus.in_ready;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int unsigned i = 0; i < N; i++)
      if (hs[i]) begin
        new_tok(i);
        if (rand_mode) bus.in_valid[i] = 1'($urandom_range(0, 1));
      end
    hs = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mid();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] ta, tb2, tp;
    int           n;
    int           exp2[6];
    exp2 = '{0, 3, 8, 0, 3, 8};

    bus.en = '1; bus.sel = '1; bus.in_valid = '1; bus.out_ready = 1'b1;
    bus.in_data = '0;
    for (int unsigned i = 0; i < N; i++) new_tok(i);

    // Reset with everything requesting
    rst_n = 1'b0;
    mid();
    check("rst_in_ready", 32'(bus.in_ready), 32'h0);
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_out_data", 32'(bus.out_data), 32'h0);
    tick();
    rst_n = 1'b1;
    mid();
    check("first_grant", 32'(bus.in_ready), 32'h001);
    check("first_out_valid", 32'(bus.out_valid), 32'h0);
    tick();

    // Inputs 0,3,8 streaming at full rate
    do_reset();
    bus.in_valid = 9'h109; bus.out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 7 && n < 6; c++) begin
      mid();
      check("onehot", 32'($countones(bus.in_ready)), 32'd1);
      if (bus.out_valid) begin
        check("rr_order", 32'(bus.out_data[W-1 -: 4]), 32'(exp2[n]));
        n++;
      end
      tick();
    end
    check("rr_throughput", 32'(n), 32'd6);

    // Fill both slots with the consumer stalled, then drain
    do_reset();
    bus.in_valid = 9'h003; bus.out_ready = 1'b0;
    mid(); check("fill_g0", 32'(bus.in_ready), 32'h001); ta = bus.in_data[0 +: W]; tick();
    mid(); check("fill_g1", 32'(bus.in_ready), 32'h002);
    check("fill_head", 32'(bus.out_data), 32'(ta)); tb2 = bus.in_data[W +: W]; tick();
    bus.out_ready = 1'b1;
    mid(); check("full_no_grant", 32'(bus.in_ready), 32'h0);
    check("full_head", 32'(bus.out_data), 32'(ta)); tick();
    mid(); check("second_out", 32'(bus.out_data), 32'(tb2));
    check("regrant_wrap", 32'(bus.in_ready), 32'h001); tick();
    bus.in_valid = '0;
    repeat (3) begin mid(); tick(); end

    // Deselected input is held off until selected
    do_reset();
    bus.en = 9'h1FF; bus.sel = 9'h1FB; bus.in_valid = 9'h004; bus.out_ready = 1'b1;
    repeat (4) begin
      mid();
      check("desel_ready", 32'(bus.in_ready), 32'h0);
      check("desel_valid", 32'(bus.out_valid), 32'h0);
      tick();
    end
    bus.sel = 9'h1FF;
    mid(); check("sel_grant", 32'(bus.in_ready), 32'h004); ta = bus.in_data[2*W +: W]; tick();
    mid(); check("sel_out_valid", 32'(bus.out_valid), 32'h1);
    check("sel_out_data", 32'(bus.out_data), 32'(ta)); tick();
    bus.in_valid = '0;

    // Simultaneous push/pop at one entry, then stall at full
    do_reset();
    bus.in_valid = 9'h001; bus.out_ready = 1'b1;
    mid(); tp = bus.in_data[0 +: W]; tick();
    repeat (3) begin
      mid(); check("pushpop_order", 32'(bus.out_data), 32'(tp));
      tp = bus.in_data[0 +: W]; tick();
    end
    bus.out_ready = 1'b0;
    mid(); check("stall_head", 32'(bus.out_data), 32'(tp)); tick();
    repeat (3) begin
      mid();
      check("stall_ready", 32'(bus.in_ready), 32'h0);
      check("stall_stable", 32'(bus.out_data), 32'(tp));
      tick();
    end

    // Reset while full
    rst_n = 1'b0;
    mid(); tick();
    mid(); check("rst_full_valid", 32'(bus.out_valid), 32'h0); tick();
    bus.in_valid = '1; rst_n = 1'b1;
    mid(); check("rst_restart", 32'(bus.in_ready), 32'h001); tick();

    // Randomized traffic
    rand_mode = 1'b1;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) begin
        bus.en  = 9'($urandom | $urandom);
        bus.sel = 9'($urandom | $urandom);
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 299) != 0);
      for (int unsigned i = 0; i < N; i++)
        if (!bus.in_valid[i] && $urandom_range(0, 2) == 0) begin
          bus.in_valid[i] = 1'b1;
          new_tok(i);
        end
      mid();
      tick();
    end
    rst_n = 1'b1;
    mid();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
